// File: rtl/ace_snoop_pkg.sv
// rtl/ace_snoop_pkg.sv - ACE snoop field encodings and initiator FSM state codes
package ace_snoop_pkg;

  localparam int RESP_DATA_TRANSFER = 0;
  localparam int RESP_ERROR         = 1;
  localparam int RESP_PASS_DIRTY    = 2;
  localparam int RESP_IS_SHARED     = 3;
  localparam int RESP_WAS_UNIQUE    = 4;

  localparam logic [3:0] SNOOP_READ_ONCE     = 4'b0000;
  localparam logic [3:0] SNOOP_READ_SHARED   = 4'b0001;
  localparam logic [3:0] SNOOP_READ_UNIQUE   = 4'b0111;
  localparam logic [3:0] SNOOP_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] SNOOP_MAKE_INVALID  = 4'b1101;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AC   = 3'd1;
  localparam logic [2:0] ST_CR   = 3'd2;
  localparam logic [2:0] ST_CD   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/cd_line_collector.sv
// rtl/cd_line_collector.sv - assembles CD beats into a cache line and flags framing errors
module cd_line_collector #(
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    s_tready_i,
  input  logic                    s_tvalid_i,
  input  logic [DATA_W-1:0]       s_tdata_i,
  input  logic                    s_tlast_i,
  output logic                    last_o,
  output logic [DATA_W*BEATS-1:0] line_o,
  output logic                    frame_err_o
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [BW-1:0] ONE       = BW'(1);

  logic [BW-1:0]           beat_q;
  logic                    full_q;
  logic [DATA_W*BEATS-1:0] line_q;
  logic                    err_q;
  logic                    hs;

  assign hs          = s_tvalid_i & s_tready_i;
  assign last_o      = hs & s_tlast_i;
  assign line_o      = line_q;
  assign frame_err_o = err_q;

  // full_q separates "last slot written" from "beat beyond the line", since beat_q saturates
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q <= '0;
      full_q <= 1'b0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else if (clear_i) begin
      beat_q <= '0;
      full_q <= 1'b0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else if (hs) begin
      if (!full_q) begin
        line_q[beat_q*DATA_W +: DATA_W] <= s_tdata_i;
        if (beat_q == LAST_BEAT) full_q <= 1'b1;
        else                     beat_q <= beat_q + ONE;
      end else begin
        err_q <= 1'b1;
      end
      if (s_tlast_i && (beat_q != LAST_BEAT)) err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/ace_snoop_initiator.sv
// rtl/ace_snoop_initiator.sv - single-outstanding ACE snoop initiator (AC issue, CR capture, CD line)
module ace_snoop_initiator
  import ace_snoop_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_ACE_DATA_WIDTH   = 128,
  parameter int C_ACE_ADDR_WIDTH   = 44,
  parameter int CD_BEATS           = 4
) (
  input  logic                               ace_aclk,
  input  logic                               ace_aresetn,
  input  logic                               i_start,
  input  logic [C_ACE_ADDR_WIDTH-1:0]        i_addr,
  input  logic [3:0]                         i_snoop,
  input  logic [2:0]                         i_prot,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      i_timeout_reg,
  output logic                               o_acvalid,
  output logic [C_ACE_ADDR_WIDTH-1:0]        o_acaddr,
  output logic [3:0]                         o_acsnoop,
  output logic [2:0]                         o_acprot,
  input  logic                               i_acready,
  input  logic                               i_crvalid,
  input  logic [4:0]                         i_crresp,
  output logic                               o_crready,
  input  logic                               i_cdvalid,
  input  logic [C_ACE_DATA_WIDTH-1:0]        i_cddata,
  input  logic                               i_cdlast,
  output logic                               o_cdready,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [4:0]                         o_resp,
  output logic [C_ACE_DATA_WIDTH*CD_BEATS-1:0] o_cache_line,
  output logic [1:0]                         o_error,
  output logic [2:0]                         o_state
);

  localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE = C_S_AXI_DATA_WIDTH'(1);

  logic [2:0]                      state_q, state_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]   cnt_q, cnt_inc;
  logic [C_ACE_ADDR_WIDTH-1:0]     addr_q;
  logic [3:0]                      snoop_q;
  logic [2:0]                      prot_q;
  logic [4:0]                      resp_q;
  logic                            to_err_q;
  logic                            start_acc, in_wait, wait_hs, timeout_hit;
  logic                            cd_active, cd_last, cd_err;

  assign start_acc = (state_q == ST_IDLE) & i_start;
  assign cd_active = (state_q == ST_CD);
  assign in_wait   = (state_q == ST_CR) | cd_active;
  assign wait_hs   = ((state_q == ST_CR) & i_crvalid) | (cd_active & i_cdvalid);
  assign cnt_inc   = cnt_q + CNT_ONE;
  // Compare the value the counter is about to take, so a limit of N leaves the state N cycles after entry
  assign timeout_hit = in_wait & (|i_timeout_reg) & (cnt_inc == i_timeout_reg) & ~wait_hs;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_AC;
      ST_AC:   if (i_acready) state_d = ST_CR;
      ST_CR: begin
        if (i_crvalid)        state_d = i_crresp[RESP_DATA_TRANSFER] ? ST_CD : ST_DONE;
        else if (timeout_hit) state_d = ST_DONE;
      end
      ST_CD:   if (cd_last || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
    if (!ace_aresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      snoop_q  <= '0;
      prot_q   <= '0;
      resp_q   <= '0;
      to_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (!in_wait || state_d != state_q) ? '0 : cnt_inc;
      if (start_acc) begin
        addr_q   <= i_addr;
        snoop_q  <= i_snoop;
        prot_q   <= i_prot;
        resp_q   <= '0;
        to_err_q <= 1'b0;
      end
      if (state_q == ST_CR && i_crvalid) resp_q <= i_crresp;
      if (timeout_hit) to_err_q <= 1'b1;
    end
  end

  cd_line_collector #(
    .DATA_W (C_ACE_DATA_WIDTH),
    .BEATS  (CD_BEATS)
  ) u_cd (
    .clk_i       (ace_aclk),
    .rst_ni      (ace_aresetn),
    .clear_i     (start_acc),
    .s_tready_i  (cd_active),
    .s_tvalid_i  (i_cdvalid),
    .s_tdata_i   (i_cddata),
    .s_tlast_i   (i_cdlast),
    .last_o      (cd_last),
    .line_o      (o_cache_line),
    .frame_err_o (cd_err)
  );

  assign o_acvalid = (state_q == ST_AC);
  assign o_acaddr  = addr_q;
  assign o_acsnoop = snoop_q;
  assign o_acprot  = prot_q;
  assign o_crready = (state_q == ST_CR);
  assign o_cdready = cd_active;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = (state_q == ST_DONE);
  assign o_resp    = resp_q;
  assign o_error   = {cd_err, to_err_q};
  assign o_state   = state_q;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// tb/tb_ace_snoop_initiator.sv - directed self-checking bench for ace_snoop_initiator
module tb_ace_snoop_initiator;
  import ace_snoop_pkg::*;

  localparam int RW = 32;
  localparam int DW = 128;
  localparam int AW = 44;
  localparam int NB = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [AW-1:0]     i_addr = '0;
  logic [3:0]        i_snoop = '0;
  logic [2:0]        i_prot = '0;
  logic [RW-1:0]     i_timeout_reg = '0;
  logic              o_acvalid;
  logic [AW-1:0]     o_acaddr;
  logic [3:0]        o_acsnoop;
  logic [2:0]        o_acprot;
  logic              i_acready = 1'b0;
  logic              i_crvalid = 1'b0;
  logic [4:0]        i_crresp = '0;
  logic              o_crready;
  logic              i_cdvalid = 1'b0;
  logic [DW-1:0]     i_cddata = '0;
  logic              i_cdlast = 1'b0;
  logic              o_cdready;
  logic              o_busy;
  logic              o_done;
  logic [4:0]        o_resp;
  logic [DW*NB-1:0]  o_cache_line;
  logic [1:0]        o_error;
  logic [2:0]        o_state;

  logic [DW-1:0]     bd [0:5];
  logic [DW*NB-1:0]  exp_line;
  int                n_cmp = 0;
  int                n_err = 0;

  always #5 clk = ~clk;

  ace_snoop_initiator #(
    .C_S_AXI_DATA_WIDTH (RW),
    .C_ACE_DATA_WIDTH   (DW),
    .C_ACE_ADDR_WIDTH   (AW),
    .CD_BEATS           (NB)
  ) dut (
    .ace_aclk      (clk),
    .ace_aresetn   (rst_n),
    .i_start       (i_start),
    .i_addr        (i_addr),
    .i_snoop       (i_snoop),
    .i_prot        (i_prot),
    .i_timeout_reg (i_timeout_reg),
    .o_acvalid     (o_acvalid),
    .o_acaddr      (o_acaddr),
    .o_acsnoop     (o_acsnoop),
    .o_acprot      (o_acprot),
    .i_acready     (i_acready),
    .i_crvalid     (i_crvalid),
    .i_crresp      (i_crresp),
    .o_crready     (o_crready),
    .i_cdvalid     (i_cdvalid),
    .i_cddata      (i_cddata),
    .i_cdlast      (i_cdlast),
    .o_cdready     (o_cdready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_resp        (o_resp),
    .o_cache_line  (o_cache_line),
    .o_error       (o_error),
    .o_state       (o_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse plus immediate AC handshake; returns with the DUT in CR
  task automatic issue(input logic [AW-1:0] a, input logic [3:0] s, input logic [2:0] p);
    i_start = 1'b1; i_addr = a; i_snoop = s; i_prot = p;
    tick();
    i_start = 1'b0; i_acready = 1'b1;
    tick();
    i_acready = 1'b0;
  endtask

  task automatic cr_hs(input logic [4:0] r);
    i_crvalid = 1'b1; i_crresp = r;
    tick();
    i_crvalid = 1'b0; i_crresp = '0;
  endtask

  task automatic send_beat(input int idx, input logic last);
    i_cdvalid = 1'b1; i_cddata = bd[idx]; i_cdlast = last;
    tick();
    i_cdvalid = 1'b0; i_cdlast = 1'b0; i_cddata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (o_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state got %0d want 0", o_state); end
    n_cmp++; if ({o_acvalid, o_crready, o_cdready, o_busy, o_done} !== 5'b0) begin n_err++; $display("FAIL rst_ctrl got %b want 00000", {o_acvalid, o_crready, o_cdready, o_busy, o_done}); end
    n_cmp++; if (o_cache_line !== '0 || o_resp !== 5'd0 || o_error !== 2'd0 || o_acaddr !== '0) begin n_err++; $display("FAIL rst_data line %h resp %h err %b addr %h want all 0", o_cache_line, o_resp, o_error, o_acaddr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_unique();
    i_start = 1'b1; i_addr = 44'h1000_0040; i_snoop = SNOOP_READ_UNIQUE; i_prot = 3'b010;
    tick();
    i_start = 1'b0; i_addr = '0;
    n_cmp++; if (o_acvalid !== 1'b1 || o_busy !== 1'b1) begin n_err++; $display("FAIL ru_acvalid got %b/%b want 1/1", o_acvalid, o_busy); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (o_acvalid !== 1'b1 || o_acaddr !== 44'h1000_0040 || o_acsnoop !== 4'b0111 || o_acprot !== 3'b010) begin n_err++; $display("FAIL ru_ac_hold%0d got v%b a%h s%b p%b", k, o_acvalid, o_acaddr, o_acsnoop, o_acprot); end
    end
    i_acready = 1'b1;
    tick();
    i_acready = 1'b0;
    n_cmp++; if (o_acvalid !== 1'b0 || o_crready !== 1'b1) begin n_err++; $display("FAIL ru_cr_entry got acvalid %b crready %b want 0 1", o_acvalid, o_crready); end
    cr_hs(5'b00001);
    n_cmp++; if (o_resp !== 5'h01 || o_cdready !== 1'b1) begin n_err++; $display("FAIL ru_cr got resp %h cdready %b want 01 1", o_resp, o_cdready); end
    for (int b = 0; b < 4; b++) send_beat(b, b == 3);
    n_cmp++; if (o_done !== 1'b1 || o_busy !== 1'b1) begin n_err++; $display("FAIL ru_done got done %b busy %b want 1 1", o_done, o_busy); end
    tick();
    n_cmp++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin n_err++; $display("FAIL ru_done_pulse got done %b busy %b want 0 0", o_done, o_busy); end
    exp_line = {bd[3], bd[2], bd[1], bd[0]};
    n_cmp++; if (o_cache_line !== exp_line) begin n_err++; $display("FAIL ru_line got %h want %h", o_cache_line, exp_line); end
    n_cmp++; if (o_resp !== 5'h01 || o_error !== 2'b00) begin n_err++; $display("FAIL ru_status got resp %h err %b want 01 00", o_resp, o_error); end
  endtask

  task automatic test_make_invalid();
    issue(44'h2000_0080, SNOOP_MAKE_INVALID, 3'b000);
    n_cmp++; if (o_crready !== 1'b1 || o_cdready !== 1'b0) begin n_err++; $display("FAIL mi_cr got crready %b cdready %b want 1 0", o_crready, o_cdready); end
    cr_hs(5'b00000);
    n_cmp++; if (o_done !== 1'b1 || o_cdready !== 1'b0) begin n_err++; $display("FAIL mi_done got done %b cdready %b want 1 0", o_done, o_cdready); end
    tick();
    n_cmp++; if (o_cache_line !== '0 || o_resp !== 5'd0 || o_error !== 2'd0) begin n_err++; $display("FAIL mi_status got line %h resp %h err %b want 0", o_cache_line, o_resp, o_error); end
  endtask

  task automatic test_short_line();
    issue(44'h3000_0000, SNOOP_READ_SHARED, 3'b001);
    cr_hs(5'b00001);
    send_beat(0, 1'b0);
    send_beat(1, 1'b1);
    n_cmp++; if (o_done !== 1'b1 || o_error !== 2'b10) begin n_err++; $display("FAIL short_err got done %b err %b want 1 10", o_done, o_error); end
    exp_line = '0;
    exp_line[2*DW-1:0] = {bd[1], bd[0]};
    n_cmp++; if (o_cache_line !== exp_line) begin n_err++; $display("FAIL short_line got %h want %h", o_cache_line, exp_line); end
    tick();
  endtask

  task automatic test_overflow();
    issue(44'h3000_0040, SNOOP_READ_ONCE, 3'b000);
    cr_hs(5'b00001);
    for (int b = 0; b < 5; b++) send_beat(b, b == 4);
    exp_line = {bd[3], bd[2], bd[1], bd[0]};
    n_cmp++; if (o_done !== 1'b1 || o_error !== 2'b10 || o_cache_line !== exp_line) begin n_err++; $display("FAIL ovf got done %b err %b line %h want 1 10 %h", o_done, o_error, o_cache_line, exp_line); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    i_timeout_reg = 32'd16;
    issue(44'h4000_0000, SNOOP_CLEAN_INVALID, 3'b000);
    n = 0;
    while (o_done !== 1'b1 && n < 40) begin tick(); n++; end
    n_cmp++; if (n != 16) begin n_err++; $display("FAIL to_latency got %0d want 16", n); end
    n_cmp++; if (o_error !== 2'b01) begin n_err++; $display("FAIL to_err got %b want 01", o_error); end
    tick();
    i_timeout_reg = '0;
    issue(44'h4000_0040, SNOOP_CLEAN_INVALID, 3'b000);
    repeat (50) tick();
    n_cmp++; if (o_state !== ST_CR || o_crready !== 1'b1 || o_done !== 1'b0) begin n_err++; $display("FAIL to_disabled got state %0d crready %b done %b want 2 1 0", o_state, o_crready, o_done); end
    cr_hs(5'b00000);
    n_cmp++; if (o_done !== 1'b1 || o_error !== 2'b00) begin n_err++; $display("FAIL to_disabled_exit got done %b err %b want 1 00", o_done, o_error); end
    tick();
  endtask

  task automatic test_start_during_cd();
    issue(44'hABC_0000_0080, SNOOP_READ_ONCE, 3'b100);
    cr_hs(5'b01001);
    send_beat(0, 1'b0);
    i_start = 1'b1; i_addr = 44'h0FF_FFFF_FFC0; i_snoop = SNOOP_MAKE_INVALID;
    tick();
    i_start = 1'b0;
    n_cmp++; if (o_state !== ST_CD || o_acaddr !== 44'hABC_0000_0080 || o_acsnoop !== 4'b0000) begin n_err++; $display("FAIL busy_start got state %0d addr %h snoop %b want 3 abc00000080 0000", o_state, o_acaddr, o_acsnoop); end
    for (int b = 1; b < 4; b++) send_beat(b, b == 3);
    exp_line = {bd[3], bd[2], bd[1], bd[0]};
    n_cmp++; if (o_done !== 1'b1 || o_error !== 2'b00 || o_cache_line !== exp_line || o_resp !== 5'h09) begin n_err++; $display("FAIL busy_done got done %b err %b resp %h line %h", o_done, o_error, o_resp, o_cache_line); end
    tick();
  endtask

  task automatic test_reset_mid_cd();
    issue(44'h5000_0000, SNOOP_READ_SHARED, 3'b000);
    cr_hs(5'b00001);
    send_beat(0, 1'b0);
    send_beat(1, 1'b0);
    i_cdvalid = 1'b1; i_cddata = bd[2];
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (o_state !== ST_IDLE || o_busy !== 1'b0 || o_cdready !== 1'b0) begin n_err++; $display("FAIL arst_ctrl got state %0d busy %b cdready %b want 0 0 0", o_state, o_busy, o_cdready); end
    n_cmp++; if (o_resp !== 5'd0 || o_cache_line !== '0 || o_acaddr !== '0 || o_error !== 2'd0) begin n_err++; $display("FAIL arst_data got resp %h err %b addr %h line %h want 0", o_resp, o_error, o_acaddr, o_cache_line); end
    i_cdvalid = 1'b0; i_cddata = '0;
    tick();
    n_cmp++; if (o_done !== 1'b0 || o_state !== ST_IDLE) begin n_err++; $display("FAIL arst_nodone got done %b state %0d want 0 0", o_done, o_state); end
    rst_n = 1'b1;
    tick();
    issue(44'h5000_0040, SNOOP_READ_UNIQUE, 3'b000);
    cr_hs(5'b10001);
    for (int b = 2; b < 6; b++) send_beat(b, b == 5);
    exp_line = {bd[5], bd[4], bd[3], bd[2]};
    n_cmp++; if (o_done !== 1'b1 || o_error !== 2'b00 || o_resp !== 5'h11 || o_cache_line !== exp_line) begin n_err++; $display("FAIL arst_next got done %b err %b resp %h line %h", o_done, o_error, o_resp, o_cache_line); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 6; i++)
      bd[i] = {32'hA000_0000 + 32'(i), 32'h5A5A_0000 + 32'(i), 32'hDEAD_0000 + 32'(i), 32'hC0DE_0000 + 32'(i)};
    test_reset();
    test_read_unique();
    test_make_invalid();
    test_short_line();
    test_overflow();
    test_timeout();
    test_start_during_cd();
    test_reset_mid_cd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ace_snoop_initiator.md
Name: ace_snoop_initiator

Overview:
- Initiator end of the ACE snoop channels (AC request, CR response, CD data), the counterpart of our snooped-master devil logic.
- Issues one AC snoop per software/bench request, accepts the CR response, and collects the CD cache line when DataTransfer is set.
- Sits in the interconnect-emulation path of the backstabber IP so attacks can be exercised against any ACE snoop responder.
- Single outstanding snoop.

Parameters:
C_S_AXI_DATA_WIDTH, 32, width of timeout config register
C_ACE_DATA_WIDTH, 128, CD data beat width
C_ACE_ADDR_WIDTH, 44, AC address width
CD_BEATS, 4, beats per cache line (64 B line at 128-bit)

Ports:
ace_aclk  in  1  clock
ace_aresetn  in  1  reset; one clock, reset is asynchronous and active-low
i_start  in  1  request pulse; sampled only in IDLE
i_addr  in  C_ACE_ADDR_WIDTH  snoop address
i_snoop  in  4  ACSNOOP encoding
i_prot  in  3  ACPROT
i_timeout_reg  in  C_S_AXI_DATA_WIDTH  CR/CD timeout in cycles; 0 disables
o_acvalid  out  1  AC valid
o_acaddr  out  C_ACE_ADDR_WIDTH  AC address
o_acsnoop  out  4  AC snoop type
o_acprot  out  3  AC prot
i_acready  in  1  AC ready
i_crvalid  in  1  CR valid
i_crresp  in  5  CR response: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique
o_crready  out  1  CR ready
i_cdvalid  in  1  CD valid
i_cddata  in  C_ACE_DATA_WIDTH  CD data
i_cdlast  in  1  CD last
o_cdready  out  1  CD ready
o_busy  out  1  high from accepted start until DONE exits
o_done  out  1  one-cycle completion pulse
o_resp  out  5  captured CRRESP
o_cache_line  out  C_ACE_DATA_WIDTH*CD_BEATS  collected line; beat0 in bits [127:0]
o_error  out  2  [0] timeout, [1] CD framing error
o_state  out  3  FSM state, debug

Behaviour:
- Reset: all outputs 0; FSM enters IDLE. Reset mid-transaction aborts immediately with no done pulse.
- IDLE:
  - i_start=1 latches addr, snoop and prot.
  - Clears o_resp, o_cache_line and o_error.
  - Goes to AC; o_acvalid=1 on the next cycle (1-cycle latency).
- AC:
  - o_acvalid and payload stay stable until i_acready=1; no timeout here, because valid must not drop.
  - On handshake, goes to CR; o_acvalid=0 on the next cycle.
- CR:
  - o_crready=1. On i_crvalid, captures i_crresp into o_resp.
  - If crresp[0]=1, goes to CD; otherwise goes to DONE.
- CD:
  - o_cdready=1. Each handshake writes i_cddata to slot beat_cnt; beat_cnt is 2-bit and saturates at CD_BEATS-1.
  - i_cdlast with beat_cnt==CD_BEATS-1 goes to DONE cleanly.
  - i_cdlast earlier sets o_error[1] and goes to DONE.
  - A beat beyond CD_BEATS without last: data dropped, o_error[1] set, keep draining until last.
- CD is accepted only in CD state (o_cdready=0 elsewhere). Responders must hold CD until CR is accepted; this is decided for this block.
- DONE: o_done=1 for exactly one cycle, o_busy=0 on the next cycle, returns to IDLE. A start pulse in DONE is ignored.
- Timeout:
  - A 32-bit counter clears on state entry and runs in CR and CD.
  - When the counter equals i_timeout_reg (nonzero), set o_error[0] and go to DONE.
  - Simultaneous handshake and timeout: the handshake wins.
- i_start while busy is ignored. o_resp, o_cache_line and o_error hold until the next accepted start.

Decomposition:
- Package ace_snoop_pkg holds:
  - CRRESP bit indices;
  - ACSNOOP constants: ReadOnce 0000, ReadShared 0001, ReadUnique 0111, CleanInvalid 1001, MakeInvalid 1101;
  - the state encoding IDLE, AC, CR, CD, DONE.
- Sub-module cd_line_collector holds the beat counter, line register and framing-error logic, and is reusable by the passive devil.

Test Plan:
- ReadUnique snoop to 0x0000_1000_0040, acready after 3 cycles, crresp=5'b00001, 4 beats A0..A3 with last on beat 3 -> o_cache_line={A3,A2,A1,A0}, o_resp=0x01, o_error=0, single o_done pulse.
- MakeInvalid, crresp=5'b00000 -> no o_cdready, o_done 1 cycle after the CR handshake, o_cache_line=0.
- crresp=1, last on beat 1 -> o_error=2'b10, beats 0-1 stored, upper line bits 0.
- i_timeout_reg=16, crvalid never asserted -> o_done exactly 16 cycles after CR entry, o_error=2'b01; timeout=0 -> stays in CR indefinitely.
- i_start pulsed during CD -> ignored, latched addr unchanged.
- ace_aresetn low during CD beat 2 -> all outputs 0 asynchronously, IDLE afterward, next snoop completes normally.
